seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: W, 8, operand width in bits; legal range 4..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 Port: ena  input  1  enable; when low, all state holds and no handshake completes.
REQ-005 Port: in_valid  input  1  command valid.
REQ-006 Port: in_ready  output  1  high only in IDLE; command accepted when in_valid && in_ready && ena.
REQ-007 Port: op  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 CMP.
REQ-008 Port: a, b  input  W each  unsigned operands.
REQ-009 Port: out_valid  output  1  result valid; held until consumed.
REQ-010 Port: out_ready  input  1  consumer ready; result consumed when out_valid && out_ready && ena.
REQ-011 Port: result  output  2W  result word, registered.
REQ-012 Port: flags  output  4  {dz, ovf, carry, zero}, registered with result.

Function
REQ-013 FSM states IDLE, BUSY, DONE; accept moves IDLE->BUSY (MUL/DIV) or IDLE->DONE (others); BUSY->DONE after the last iteration; DONE->IDLE on consume.
REQ-014 Single-cycle ops: out_valid rises the cycle after accept (latency 1).
REQ-015 MUL: shift-add, one bit per cycle, W iterations; out_valid rises W+1 cycles after accept; result = a*b, full 2W bits.
REQ-016 DIV: restoring, one bit per cycle, W iterations; out_valid rises W+1 cycles after accept; result = {remainder, quotient}, each W bits.
REQ-017 DIV with b==0: no iteration; latency 1; quotient all ones, remainder = a, dz=1.
REQ-018 ADD: result[W:0] = a+b, carry = result[W]; ovf = signed overflow of the W-bit sum; upper bits zero.
REQ-019 SUB: result[W-1:0] = a-b mod 2^W, carry = borrow (a<b); ovf = signed overflow; upper bits zero.
REQ-020 AND/OR/XOR: result[W-1:0] = bitwise op; upper bits zero; carry=ovf=0.
REQ-021 CMP: result = 0; carry = (a<b); zero = (a==b); ovf=0.
REQ-022 zero flag = (result==0) for all ops except CMP; dz=0 for all ops except REQ-017.
REQ-023 Operands and op are latched at accept; input changes during BUSY/DONE have no effect.
REQ-024 in_ready is low in BUSY and DONE; a new command is never accepted in the cycle of consume (one IDLE cycle minimum between results).
REQ-025 result and flags hold stable while out_valid is high and not consumed; they keep their last value after consume.
REQ-026 ena low freezes the iteration counter, datapath and FSM for any number of cycles; latency counts only ena-high cycles.

Reset
REQ-027 On rst_n low at a clock edge: state=IDLE, result=0, flags=0, out_valid=0, in_ready=0 for that cycle, counter=0.
REQ-028 Reset mid-operation (BUSY or DONE) aborts the command; no result is ever presented for it.
REQ-029 in_ready rises the first cycle after rst_n is sampled high.

Structure
REQ-030 Shared package alu_pkg holds the opcode enum, FSM state enum and flag bit-index constants.
REQ-031 One sub-module, alu_iter_core, implements the iterative MUL/DIV datapath (start, op, a, b, step enable, done, result); seq_alu holds FSM, handshake, single-cycle ops and output registers.

Verification (W=8)
REQ-032 ADD a=15,b=0 -> one cycle later result=0x000F, flags=0000; ADD 200+100 -> result=0x012C, carry=1.
REQ-033 SUB a=10,b=20 -> result=0x00F6, carry=1, zero=0; SUB 31-31 -> result=0, zero=1.
REQ-034 MUL a=255,b=255 -> out_valid exactly 9 cycles after accept, result=0xFE01; in_ready low throughout.
REQ-035 DIV a=10,b=2 -> result=0x0005 (r=0,q=5) after 9 cycles; DIV a=10,b=0 -> after 1 cycle result=0x0AFF, dz=1.
REQ-036 Backpressure: out_ready low 5 cycles, then high -> result stable all 5 cycles, consumed once, in_ready high next cycle; ena low 3 cycles mid-MUL -> latency 12.
REQ-037 Reset at cycle 4 of a MUL -> out_valid never rises for it; next ADD 1+1 returns 0x0002 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states
// and bit positions inside the 4-bit flags word.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // flags = {dz, ovf, carry, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_DZ    = 3;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per step.
// res/done reflect the state *after* the current step so the caller can capture on the last step.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           step,
    output logic           done,
    output logic [2*W-1:0] res
);

    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt;
    logic [W-1:0]  hi, lo, opnd;
    logic          div_q;

    logic [W:0]    sum, shl;
    logic [W-1:0]  diff, hi_nxt, lo_nxt;
    logic          ge;

    // hi/lo hold {product_hi, multiplier} for MUL and {remainder, dividend} for DIV
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shl    = {hi, lo[W-1]};
        ge     = (shl >= {1'b0, opnd});
        diff   = shl[W-1:0] - opnd;
        hi_nxt = sum[W:1];
        lo_nxt = {sum[0], lo[W-1:1]};
        if (div_q) begin
            hi_nxt = ge ? diff : shl[W-1:0];
            lo_nxt = {lo[W-2:0], ge};
        end
        res  = {hi_nxt, lo_nxt};
        done = step && (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= is_div ? a : b;
            opnd  <= is_div ? b : a;
            div_q <= is_div;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_nxt;
            lo  <= lo_nxt;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic/arith ops,
// iterative MUL/DIV through alu_iter_core, registered result and flags.
module seq_alu
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic [3:0]     flags
);

    localparam int RW = 2 * W;

    state_e        state, state_nxt;
    logic          live;
    logic          accept, consume, iter_go, step;
    logic          core_done;
    logic [RW-1:0] core_res;
    logic [RW-1:0] sc_res;
    logic [3:0]    sc_flags;
    logic [W:0]    add_s, sub_s;
    op_e           op_c;

    // live keeps in_ready low for the reset cycle itself
    assign in_ready  = live && (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready && ena;
    assign consume   = out_valid && out_ready && ena;
    assign op_c      = op_e'(op);
    assign iter_go   = (op_c == OP_MUL) || ((op_c == OP_DIV) && (b != '0));
    assign step      = ena && (state == S_BUSY);

    alu_iter_core #(.W(W)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && iter_go),
        .is_div (op_c == OP_DIV),
        .a      (a),
        .b      (b),
        .step   (step),
        .done   (core_done),
        .res    (core_res)
    );

    always_comb begin
        add_s    = {1'b0, a} + {1'b0, b};
        sub_s    = {1'b0, a} - {1'b0, b};
        sc_res   = '0;
        sc_flags = '0;
        case (op_c)
            OP_ADD: begin
                sc_res              = RW'(add_s);
                sc_flags[FLAG_CARRY] = add_s[W];
                sc_flags[FLAG_OVF]   = (a[W-1] == b[W-1]) && (add_s[W-1] != a[W-1]);
            end
            OP_SUB: begin
                sc_res              = RW'(sub_s[W-1:0]);
                sc_flags[FLAG_CARRY] = (a < b);
                sc_flags[FLAG_OVF]   = (a[W-1] != b[W-1]) && (sub_s[W-1] != a[W-1]);
            end
            OP_DIV: begin
                // only reached here for b == 0
                sc_res            = {a, {W{1'b1}}};
                sc_flags[FLAG_DZ] = 1'b1;
            end
            OP_AND:  sc_res = RW'(a & b);
            OP_OR:   sc_res = RW'(a | b);
            OP_XOR:  sc_res = RW'(a ^ b);
            OP_CMP:  sc_flags[FLAG_CARRY] = (a < b);
            default: sc_res = '0;
        endcase
        if (op_c == OP_CMP) sc_flags[FLAG_ZERO] = (a == b);
        else                sc_flags[FLAG_ZERO] = (sc_res == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = iter_go ? S_BUSY : S_DONE;
            S_BUSY:  if (core_done) state_nxt = S_DONE;
            S_DONE:  if (consume) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            live   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            live <= 1'b1;
            if (ena) begin
                state <= state_nxt;
                if (accept && !iter_go) begin
                    result <= sc_res;
                    flags  <= sc_flags;
                end else if (core_done) begin
                    result <= core_res;
                    flags  <= {3'b000, core_res == '0};
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (W=8): vector table for every opcode plus
// hand sequences for backpressure, enable stalls and mid-operation reset.
module tb_seq_alu;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     op = 3'd0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic [3:0]     flags;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    always #5 clk = ~clk;

    seq_alu #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept_cmd(input string name, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // scramble inputs: the DUT must have latched them
        op = 3'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic do_op(input string name, input vec_t v);
        int lat;
        logic saw_ready;
        accept_cmd(name, v.op, v.a, v.b);
        lat = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) saw_ready = 1'b1;
            tick();
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(v.lat));
        chk({name, "_busy_ready"}, 32'(saw_ready), 32'd0);
        chk({name, "_result"}, 32'(result), 32'(v.res));
        chk({name, "_flags"}, 32'(flags), 32'(v.fl));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_consumed"}, 32'(out_valid), 32'd0);
        chk({name, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic any_valid;
        logic stable;

        //           op    a      b      result    {dz,ovf,c,z} lat
        vecs[0]  = '{3'd0, 8'd15,  8'd0,   16'h000F, 4'b0000, 1};
        vecs[1]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 4'b0010, 1};
        vecs[2]  = '{3'd1, 8'd10,  8'd20,  16'h00F6, 4'b0010, 1};
        vecs[3]  = '{3'd1, 8'd31,  8'd31,  16'h0000, 4'b0001, 1};
        vecs[4]  = '{3'd2, 8'd255, 8'd255, 16'hFE01, 4'b0000, 9};
        vecs[5]  = '{3'd3, 8'd10,  8'd2,   16'h0005, 4'b0000, 9};
        vecs[6]  = '{3'd3, 8'd10,  8'd0,   16'h0AFF, 4'b1000, 1};
        vecs[7]  = '{3'd4, 8'hF0,  8'h3C,  16'h0030, 4'b0000, 1};
        vecs[8]  = '{3'd5, 8'hF0,  8'h0F,  16'h00FF, 4'b0000, 1};
        vecs[9]  = '{3'd6, 8'hAA,  8'hAA,  16'h0000, 4'b0001, 1};
        vecs[10] = '{3'd7, 8'd5,   8'd9,   16'h0000, 4'b0010, 1};
        vecs[11] = '{3'd7, 8'd7,   8'd7,   16'h0000, 4'b0001, 1};
        vecs[12] = '{3'd0, 8'd100, 8'd100, 16'h00C8, 4'b0100, 1};
        vecs[13] = '{3'd1, 8'h80,  8'd1,   16'h007F, 4'b0100, 1};
        vecs[14] = '{3'd0, 8'd128, 8'd128, 16'h0100, 4'b0110, 1};
        vecs[15] = '{3'd3, 8'd200, 8'd7,   16'h041C, 4'b0000, 9};
        vecs[16] = '{3'd2, 8'd13,  8'd11,  16'h008F, 4'b0000, 9};
        vecs[17] = '{3'd3, 8'd3,   8'd7,   16'h0300, 4'b0000, 9};
        vecs[18] = '{3'd2, 8'd0,   8'd5,   16'h0000, 4'b0001, 9};

        // reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        chk("rst_release_ready", 32'(in_ready), 32'd0);
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // no accept while ena is low
        ena = 1'b0;
        in_valid = 1'b1;
        op = 3'd0;
        a = 8'd1;
        b = 8'd1;
        tick();
        chk("ena_low_no_accept_valid", 32'(out_valid), 32'd0);
        chk("ena_low_no_accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        ena = 1'b1;

        for (int i = 0; i < 19; i++) do_op($sformatf("vec%0d", i), vecs[i]);

        // backpressure: result must hold for 5 stalled cycles, then consume once
        accept_cmd("bp", 3'd0, 8'd3, 8'd4);
        chk("bp_valid", 32'(out_valid), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || result !== 16'h0007 || flags !== 4'b0000) stable = 1'b0;
            tick();
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_consumed", 32'(out_valid), 32'd0);
        chk("bp_ready_next", 32'(in_ready), 32'd1);
        chk("bp_result_kept", 32'(result), 32'h0007);
        tick();
        chk("bp_once", 32'(out_valid), 32'd0);

        // ena low for 3 cycles in the middle of a MUL stretches latency to 12
        accept_cmd("ena", 3'd2, 8'd255, 8'd255);
        lat = 1;
        tick();
        tick();
        lat += 2;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
        end
        ena = 1'b1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("ena_lat", 32'(lat), 32'd12);
        chk("ena_result", 32'(result), 32'hFE01);
        out_ready = 1'b1;
        ena = 1'b0;
        tick();
        chk("ena_low_no_consume", 32'(out_valid), 32'd1);
        ena = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ena_consume", 32'(out_valid), 32'd0);

        // reset in the 4th cycle of a MUL aborts it
        accept_cmd("rstmid", 3'd2, 8'd255, 8'd255);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstmid_result_cleared", 32'(result), 32'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) any_valid = 1'b1;
            tick();
        end
        chk("rstmid_no_result", 32'(any_valid), 32'd0);
        do_op("after_rst_add", '{3'd0, 8'd1, 8'd1, 16'h0002, 4'b0000, 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
